// File: rtl/spi_bitrev_slave.sv
// spi_bitrev_slave
//   SPI slave loopback target running on the system clock. sck, ss and mosi
//   are oversampled through synchroniser chains, so any CPOL/CPHA mode works
//   as long as clock runs at least 4x faster than sck.
//
//   Every word is received first (WIDTH sample edges on mosi, first bit into
//   bit 0). It is then returned on miso during the next WIDTH bit times,
//   either bit-reversed (REVERSE=1) or echoed in the same order (REVERSE=0).
//   Several words may follow each other within one ss assertion.
//
// Ports
//   clock      in   system clock, all logic on posedge
//   reset      in   synchronous active-high reset
//   sck        in   SPI clock (asynchronous to clock)
//   ss         in   slave select, active low (asynchronous to clock)
//   mosi       in   master-out data (asynchronous to clock)
//   miso       out  slave-out data, idles high
//   busy       out  high while receiving or transmitting a word
//   word_done  out  one-cycle pulse when a word's TX phase completes
//   rx_word    out  last fully received word, held until the next one lands
//   word_count out  completed words since reset, wraps at 16 bits
module spi_bitrev_slave #(
   parameter int WIDTH       = 8,
   parameter bit CPOL        = 1'b0,
   parameter bit CPHA        = 1'b0,
   parameter bit REVERSE     = 1'b1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sck,
   input  logic             ss,
   input  logic             mosi,
   output logic             miso,
   output logic             busy,
   output logic             word_done,
   output logic [WIDTH-1:0] rx_word,
   output logic [15:0]      word_count
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RX, TX} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sck_prev_q, sck_prev_d;
   logic [WIDTH-1:0]       shift_q, shift_d;
   logic [WIDTH-1:0]       rx_word_q, rx_word_d;
   logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
   logic                   miso_q, miso_d;
   logic                   word_done_q, word_done_d;
   logic [15:0]            word_count_q, word_count_d;

   logic          sck_s, ss_s, mosi_s;
   logic          sck_edge, lead_edge, trail_edge;
   logic          sample_edge, shift_edge;
   logic          last_bit;
   logic [CW-1:0] tx_idx;
   logic          tx_bit;

   // Synchroniser chains shift toward the MSB; the MSB is the usable value.
   always_comb begin
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
      ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_s       = sck_sync_q[SYNC_STAGES-1];
      ss_s        = ss_sync_q[SYNC_STAGES-1];
      mosi_s      = mosi_sync_q[SYNC_STAGES-1];
      sck_prev_d  = sck_s;
   end

   // Leading edge leaves the idle level, trailing edge returns to it.
   always_comb begin
      sck_edge    = sck_s ^ sck_prev_q;
      lead_edge   = sck_edge & (sck_prev_q == CPOL);
      trail_edge  = sck_edge & (sck_prev_q != CPOL);
      sample_edge = CPHA ? trail_edge : lead_edge;
      shift_edge  = CPHA ? lead_edge : trail_edge;
      last_bit    = (bit_cnt_q == LAST);
      tx_idx      = REVERSE ? (LAST - bit_cnt_q) : bit_cnt_q;
      tx_bit      = rx_word_q[tx_idx];
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a synced-high ss overrides any edge in the same cycle.
   always_comb begin
      state_d = state_q;
      if (ss_s) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = RX;
            RX:      if (sample_edge && last_bit) state_d = TX;
            TX:      if (sample_edge && last_bit) state_d = RX;
            default: state_d = IDLE;
         endcase
      end
   end

   // Datapath next values
   always_comb begin
      shift_d      = shift_q;
      rx_word_d    = rx_word_q;
      bit_cnt_d    = bit_cnt_q;
      miso_d       = miso_q;
      word_done_d  = 1'b0;
      word_count_d = word_count_q;
      if (ss_s) begin
         // Abort: the partial word is dropped, rx_word and the count survive.
         shift_d   = '0;
         bit_cnt_d = '0;
         miso_d    = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               bit_cnt_d = '0;
               miso_d    = 1'b1;
            end
            RX: begin
               if (sample_edge) begin
                  shift_d[bit_cnt_q] = mosi_s;
                  if (last_bit) begin
                     rx_word_d = shift_d;
                     bit_cnt_d = '0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end else if (shift_edge) begin
                  miso_d = 1'b1;
               end
            end
            TX: begin
               // Sample edges only pace the reply; miso moves on shift edges.
               if (sample_edge) begin
                  if (last_bit) begin
                     bit_cnt_d    = '0;
                     word_done_d  = 1'b1;
                     word_count_d = word_count_q + 16'd1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end else if (shift_edge) begin
                  miso_d = tx_bit;
               end
            end
            default: begin
               miso_d = 1'b1;
            end
         endcase
      end
   end

   // Datapath and synchroniser registers
   always_ff @(posedge clock) begin
      if (reset) begin
         sck_sync_q   <= {SYNC_STAGES{CPOL}};
         ss_sync_q    <= '1;
         mosi_sync_q  <= '0;
         sck_prev_q   <= CPOL;
         shift_q      <= '0;
         rx_word_q    <= '0;
         bit_cnt_q    <= '0;
         miso_q       <= 1'b1;
         word_done_q  <= 1'b0;
         word_count_q <= '0;
      end else begin
         sck_sync_q   <= sck_sync_d;
         ss_sync_q    <= ss_sync_d;
         mosi_sync_q  <= mosi_sync_d;
         sck_prev_q   <= sck_prev_d;
         shift_q      <= shift_d;
         rx_word_q    <= rx_word_d;
         bit_cnt_q    <= bit_cnt_d;
         miso_q       <= miso_d;
         word_done_q  <= word_done_d;
         word_count_q <= word_count_d;
      end
   end

   // Outputs
   always_comb begin
      busy       = (state_q != IDLE);
      miso       = miso_q;
      word_done  = word_done_q;
      rx_word    = rx_word_q;
      word_count = word_count_q;
   end

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// Bench for spi_bitrev_slave. Three instances:
//   u0: WIDTH=8,  CPOL=0, CPHA=0, REVERSE=1  (bus 0)
//   u1: WIDTH=8,  CPOL=0, CPHA=0, REVERSE=0  (bus 0, same stimulus as u0)
//   u2: WIDTH=16, CPOL=1, CPHA=1, REVERSE=1  (bus 1)
// The model is kept at the SPI-transaction level: the master task knows which
// bit of which word it is clocking and sets the expected slave outputs from
// that; a compare process checks every settled cycle.
module tb_spi_bitrev_slave;

   localparam int H = 8;        // clock cycles per sck half period
   localparam int SETTLE = 4;   // cycles after an input change before checking

   logic clock = 1'b0;
   logic reset;
   logic sck0, ss0, mosi0, sck1, ss1, mosi1;

   logic       miso0, busy0, wd0;
   logic       miso1, busy1, wd1;
   logic       miso2, busy2, wd2;
   logic [7:0] rx0, rx1;
   logic [15:0] rx2;
   logic [15:0] cnt0, cnt1, cnt2;

   always #5 clock = ~clock;

   spi_bitrev_slave #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .REVERSE(1'b1), .SYNC_STAGES(2)) u0 (
      .clock(clock), .reset(reset), .sck(sck0), .ss(ss0), .mosi(mosi0),
      .miso(miso0), .busy(busy0), .word_done(wd0), .rx_word(rx0), .word_count(cnt0));

   spi_bitrev_slave #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .REVERSE(1'b0), .SYNC_STAGES(2)) u1 (
      .clock(clock), .reset(reset), .sck(sck0), .ss(ss0), .mosi(mosi0),
      .miso(miso1), .busy(busy1), .word_done(wd1), .rx_word(rx1), .word_count(cnt1));

   spi_bitrev_slave #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .REVERSE(1'b1), .SYNC_STAGES(2)) u2 (
      .clock(clock), .reset(reset), .sck(sck1), .ss(ss1), .mosi(mosi1),
      .miso(miso2), .busy(busy2), .word_done(wd2), .rx_word(rx2), .word_count(cnt2));

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_chg = 0;
   logic chk_en = 1'b0;

   // Transaction-level model state, one entry per instance
   logic        exp_miso [3];
   logic        exp_busy [3];
   logic [31:0] exp_rx   [3];
   int          exp_cnt  [3];
   int          exp_done [3];
   int          done_seen [3];
   logic [31:0] cap      [3];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) begin
      done_seen[0] <= done_seen[0] + (wd0 ? 1 : 0);
      done_seen[1] <= done_seen[1] + (wd1 ? 1 : 0);
      done_seen[2] <= done_seen[2] + (wd2 ? 1 : 0);
   end

   // Compare process: every settled cycle, all instances against the model.
   always @(posedge clock) begin
      #1;
      if (chk_en && (cyc - last_chg) >= SETTLE) begin
         chk("miso0", 32'(miso0), 32'(exp_miso[0]));
         chk("busy0", 32'(busy0), 32'(exp_busy[0]));
         chk("rx0",   32'(rx0),   exp_rx[0]);
         chk("cnt0",  32'(cnt0),  32'(exp_cnt[0] % 65536));
         chk("done0", 32'(wd0),   32'd0);
         chk("ndone0", 32'(done_seen[0]), 32'(exp_done[0]));
         chk("miso1", 32'(miso1), 32'(exp_miso[1]));
         chk("busy1", 32'(busy1), 32'(exp_busy[1]));
         chk("rx1",   32'(rx1),   exp_rx[1]);
         chk("cnt1",  32'(cnt1),  32'(exp_cnt[1] % 65536));
         chk("done1", 32'(wd1),   32'd0);
         chk("ndone1", 32'(done_seen[1]), 32'(exp_done[1]));
         chk("miso2", 32'(miso2), 32'(exp_miso[2]));
         chk("busy2", 32'(busy2), 32'(exp_busy[2]));
         chk("rx2",   32'(rx2),   exp_rx[2]);
         chk("cnt2",  32'(cnt2),  32'(exp_cnt[2] % 65536));
         chk("done2", 32'(wd2),   32'd0);
         chk("ndone2", 32'(done_seen[2]), 32'(exp_done[2]));
      end
   end

   function automatic int d_lo(input bit b);
      return b ? 2 : 0;
   endfunction

   function automatic int d_hi(input bit b);
      return b ? 2 : 1;
   endfunction

   function automatic logic get_miso(input int d);
      case (d)
         0: return miso0;
         1: return miso1;
         default: return miso2;
      endcase
   endfunction

   // Expected miso for bit time j of a 2*wd bit-time word cycle.
   function automatic logic expbit(input int d, input int j, input logic [31:0] w, input int wd);
      logic [31:0] t;
      int k;
      if (j < wd) return 1'b1;
      k = j - wd;
      t = (d == 1) ? (w >> k) : (w >> (wd - 1 - k));
      return t[0];
   endfunction

   task automatic half();
      repeat (H) @(negedge clock);
   endtask

   task automatic set_sck(input bit b, input logic v);
      if (b) sck1 = v; else sck0 = v;
      last_chg = cyc;
   endtask

   task automatic set_mosi(input bit b, input logic v);
      if (b) mosi1 = v; else mosi0 = v;
      last_chg = cyc;
   endtask

   task automatic set_ss(input bit b, input logic v);
      if (b) ss1 = v; else ss0 = v;
      last_chg = cyc;
      for (int d = d_lo(b); d <= d_hi(b); d++) begin
         exp_busy[d] = ~v;
         if (v) exp_miso[d] = 1'b1;
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         exp_miso[d] = 1'b1;
         exp_busy[d] = 1'b0;
         exp_rx[d]   = '0;
         exp_cnt[d]  = 0;
      end
   endtask

   task automatic clear_caps();
      for (int d = 0; d < 3; d++) cap[d] = '0;
   endtask

   task automatic on_shift(input bit b, input int j, input logic [31:0] w, input int wd);
      for (int d = d_lo(b); d <= d_hi(b); d++) exp_miso[d] = expbit(d, j, w, wd);
   endtask

   task automatic on_sample(input bit b, input int j, input logic [31:0] w, input int wd);
      for (int d = d_lo(b); d <= d_hi(b); d++) begin
         if (j == wd - 1) exp_rx[d] = w;
         if (j == 2 * wd - 1) begin
            exp_cnt[d]++;
            exp_done[d]++;
         end
      end
   endtask

   task automatic capture(input bit b, input int j, input int wd);
      if (j >= wd)
         for (int d = d_lo(b); d <= d_hi(b); d++)
            cap[d] = cap[d] | (32'(get_miso(d)) << (j - wd));
   endtask

   // Master: clocks nbits bit times of word w (RX bits, then TX bits).
   // Bus 0 is CPOL=0/CPHA=0 with 8-bit words; bus 1 is CPOL=1/CPHA=1, 16-bit.
   task automatic xfer(input bit b, input logic [31:0] w, input int nbits);
      int wd;
      logic cpol, mb;
      logic [31:0] t;
      wd = b ? 16 : 8;
      cpol = b;
      for (int j = 0; j < nbits; j++) begin
         t = w >> j;
         mb = (j < wd) ? t[0] : 1'b0;
         if (!b) begin
            set_mosi(b, mb);
            half();
            capture(b, j, wd);
            set_sck(b, ~cpol);
            on_sample(b, j, w, wd);
            half();
            set_sck(b, cpol);
            on_shift(b, (j + 1) % (2 * wd), w, wd);
         end else begin
            set_sck(b, ~cpol);
            set_mosi(b, mb);
            on_shift(b, j, w, wd);
            half();
            capture(b, j, wd);
            set_sck(b, cpol);
            on_sample(b, j, w, wd);
            half();
         end
      end
   endtask

   initial begin
      sck0 = 1'b0; ss0 = 1'b1; mosi0 = 1'b0;
      sck1 = 1'b1; ss1 = 1'b1; mosi1 = 1'b0;
      reset = 1'b1;
      for (int d = 0; d < 3; d++) exp_done[d] = 0;
      model_reset();
      clear_caps();
      repeat (4) @(negedge clock);
      reset = 1'b0;
      last_chg = cyc;
      @(posedge clock); #1;
      chk("rst_miso0", 32'(miso0), 32'd1);
      chk("rst_busy0", 32'(busy0), 32'd0);
      chk("rst_rx0",   32'(rx0),   32'd0);
      chk("rst_cnt0",  32'(cnt0),  32'd0);
      chk("rst_done0", 32'(wd0),   32'd0);
      chk("rst_rx2",   32'(rx2),   32'd0);
      chk("rst_miso2", 32'(miso2), 32'd1);
      chk_en = 1'b1;

      // sck activity with ss high must be ignored
      @(negedge clock);
      for (int i = 0; i < 20; i++) begin
         set_sck(1'b0, ~sck0);
         set_sck(1'b1, ~sck1);
         half();
      end
      chk("idle_cnt0",  32'(cnt0),  32'd0);
      chk("idle_miso0", 32'(miso0), 32'd1);
      chk("idle_busy0", 32'(busy0), 32'd0);
      chk("idle_cnt2",  32'(cnt2),  32'd0);

      // One word 0x0D (mosi 1,0,1,1,0,0,0,0)
      clear_caps();
      set_ss(1'b0, 1'b0);
      half();
      xfer(1'b0, 32'h0D, 16);
      half();
      chk("w1_busy0", 32'(busy0), 32'd1);
      set_ss(1'b0, 1'b1);
      half();
      chk("w1_rx0",   32'(rx0),  32'h0D);
      chk("w1_rx1",   32'(rx1),  32'h0D);
      chk("w1_tx0",   cap[0],    32'hB0);
      chk("w1_tx1",   cap[1],    32'h0D);
      chk("w1_cnt0",  32'(cnt0), 32'd1);
      chk("w1_ndone0", 32'(done_seen[0]), 32'd1);
      chk("w1_busy0_end", 32'(busy0), 32'd0);

      // Abort after 5 RX bits, then a full word 0xA5
      set_ss(1'b0, 1'b0);
      half();
      xfer(1'b0, 32'hFF, 5);
      half();
      set_ss(1'b0, 1'b1);
      half();
      chk("ab_busy0", 32'(busy0), 32'd0);
      chk("ab_cnt0",  32'(cnt0),  32'd1);
      chk("ab_rx0",   32'(rx0),   32'h0D);
      clear_caps();
      set_ss(1'b0, 1'b0);
      half();
      xfer(1'b0, 32'hA5, 16);
      half();
      set_ss(1'b0, 1'b1);
      half();
      chk("a5_rx0",  32'(rx0),  32'hA5);
      chk("a5_cnt0", 32'(cnt0), 32'd2);
      chk("a5_tx0",  cap[0],    32'hA5);
      chk("a5_tx1",  cap[1],    32'hA5);

      // Reset in the middle of the TX phase of 0x3C
      set_ss(1'b0, 1'b0);
      half();
      xfer(1'b0, 32'h3C, 9);
      half();
      chk("pre_rst_miso0", 32'(miso0), 32'd0);
      reset = 1'b1;
      model_reset();
      last_chg = cyc;
      @(posedge clock); #1;
      chk("mr_miso0", 32'(miso0), 32'd1);
      chk("mr_busy0", 32'(busy0), 32'd0);
      chk("mr_rx0",   32'(rx0),   32'd0);
      chk("mr_cnt0",  32'(cnt0),  32'd0);
      chk("mr_rx1",   32'(rx1),   32'd0);
      chk("mr_cnt1",  32'(cnt1),  32'd0);
      @(negedge clock);
      reset = 1'b0;
      set_ss(1'b0, 1'b1);
      half();
      clear_caps();
      set_ss(1'b0, 1'b0);
      half();
      xfer(1'b0, 32'h3C, 16);
      half();
      set_ss(1'b0, 1'b1);
      half();
      chk("ar_rx0",  32'(rx0),  32'h3C);
      chk("ar_cnt0", 32'(cnt0), 32'd1);
      chk("ar_tx0",  cap[0],    32'h3C);
      chk("ar_tx1",  cap[1],    32'h3C);

      // CPOL=1/CPHA=1, 16-bit burst: 0x8001 then 0x00FF in one ss assertion
      clear_caps();
      set_ss(1'b1, 1'b0);
      half();
      xfer(1'b1, 32'h8001, 32);
      chk("b1_rx2",  32'(rx2),  32'h8001);
      chk("b1_tx2",  cap[2],    32'h8001);
      chk("b1_cnt2", 32'(cnt2), 32'd1);
      clear_caps();
      xfer(1'b1, 32'h00FF, 32);
      chk("b2_rx2",   32'(rx2),   32'h00FF);
      chk("b2_tx2",   cap[2],     32'hFF00);
      chk("b2_cnt2",  32'(cnt2),  32'd2);
      chk("b2_busy2", 32'(busy2), 32'd1);
      half();
      set_ss(1'b1, 1'b1);
      half();
      chk("b2_busy2_end", 32'(busy2), 32'd0);
      chk("b2_ndone2", 32'(done_seen[2]), 32'd2);

      repeat (4) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_bitrev_slave.md
Name: spi_bitrev_slave

Overview:
- Parametrised SPI slave test peripheral; successor to the fixed 8-bit, SPI-clocked bit-reversal slave.
- Runs on the system clock. It oversamples sck/ss/mosi, so it supports all four CPOL/CPHA modes.
- Each word: receives WIDTH bits on mosi, then returns them on miso, bit-reversed or echoed.
- Multiple words may be transferred per ss assertion (burst). Attached to the SoC SPI master as a loopback target.

Parameters:
- WIDTH, 8: bits per word, 2..32.
- CPOL, 0: sck idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- REVERSE, 1: 1 = miso stream is the received stream in reverse bit order; 0 = echo in the same order.
- SYNC_STAGES, 2: synchroniser flops on sck, ss, mosi (≥2).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- sck  in  1  SPI clock, asynchronous to clock.
- ss  in  1  slave select, active low.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data, idle level 1.
- busy  out  1  high while in RX or TX.
- word_done  out  1  one-cycle pulse when a word's TX phase completes.
- rx_word  out  WIDTH  last fully received word; held until the next word's RX completes.
- word_count  out  16  count of completed words since reset; wraps at 0xFFFF→0.

Behaviour:
- Reset values: miso=1, busy=0, word_done=0, rx_word=0, word_count=0, state=IDLE, shift reg=0, bit counter=0.
- Synchronisation: sck, ss, mosi each pass through SYNC_STAGES flops. An edge is detected by comparing the last synced sck with its previous value.
- Edge roles:
  - leading edge = transition away from CPOL; trailing = transition back to CPOL.
  - sample edge = leading if CPHA=0, trailing if CPHA=1; shift edge = the other one.
- Clock ratio: clock frequency ≥ 4× sck frequency. miso updates one clock after the synchronised shift edge is detected.
- States:
  - IDLE: miso=1. On synced ss low, go to RX with bit counter=0. Edges seen while ss is high are ignored.
  - RX: on each sample edge, shift in mosi. Bit i received is stored at word bit i (first bit → bit 0). miso stays 1 on shift edges. After the WIDTH-th sample, load rx_word and go to TX with bit counter=0.
  - TX: on each shift edge, drive miso with word bit (WIDTH-1-k) if REVERSE=1, or bit k if REVERSE=0, where k is the TX bit index. Sample edges only advance the counter.
    - After the WIDTH-th TX sample edge: pulse word_done, increment word_count, go to RX with counter=0.
    - The next shift edge drives miso=1 until the next TX phase. This applies to both CPHA settings, since the first TX bit is driven on the first shift edge after the last RX sample.
- ss deasserted (synced high) in any state: next clock go to IDLE, miso=1, discard the partial word.
  - No word_done, word_count unchanged, rx_word unchanged if abort occurs during RX.
  - An abort during TX keeps rx_word (already loaded) but gives no word_done or count.
- busy = (state != IDLE).
- Reset mid-transfer: all state returns to reset values on that clock, regardless of ss.
- Simultaneous: if ss rises in the same clock as a detected edge, ss wins and the edge is ignored.
- No sck edges during RX/TX while ss is low: hold state indefinitely; no timeout.

Test Plan:
- WIDTH=8, CPOL=0, CPHA=0, REVERSE=1: mosi bits 1,0,1,1,0,0,0,0 then 8 more clocks → rx_word=0x0D; miso TX bits 0,0,0,0,1,1,0,1; one word_done; word_count=1.
- Same stimulus with REVERSE=0 → miso TX bits 1,0,1,1,0,0,0,0; miso=1 during all RX bits.
- CPOL=1, CPHA=1, WIDTH=16, one ss assertion:
  - word 0x8001 sent bit0 first, TX phase, then 0x00FF, TX phase.
  - → rx_word 0x8001 then 0x00FF; miso streams are the reversed streams; word_count=2; busy low only after ss rises.
- ss raised after 5 RX bits, then a full 8-bit word 0xA5 sent → rx_word=0xA5, word_count=1, miso=1 throughout the aborted portion.
- reset asserted mid-TX of word 0x3C → next clock: miso=1, busy=0, rx_word=0, word_count=0; a new transfer after reset completes correctly.
- sck toggling with ss high for 20 edges → no state change, miso=1, word_count=0.
